// File: rtl/router_pkg.sv
// Shared types and width helper for the NoC endpoint.
// Packet layout is {dst_x, dst_y, ctrl[1:0], payload}, MSB first.
package router_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_REL
  } tx_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_t;

  function automatic int pkt_w(input int payload, input int x_bits, input int y_bits);
    return x_bits + y_bits + 2 + payload;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit flop-chain synchronizer for asynchronous handshake inputs.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/noc_endpoint.sv
// NoC endpoint: local valid/ready ports bridged to 4-phase req/ack links
// toward and from a router that runs on an unrelated clock.
//
// state    | meaning
// TX_IDLE  | ready for a local packet (once ack_sync is low and settled)
// TX_REQ   | net_req_o high, packet held, waiting for ack_sync
// TX_REL   | req dropped, waiting for ack_sync to fall
// RX_IDLE  | waiting for req_sync with an empty buffer
// RX_ACK   | packet captured, net_ack_o high until req_sync falls
module noc_endpoint
  import router_pkg::*;
#(
  parameter int PAYLOAD     = 32,
  parameter int X_BITS      = 1,
  parameter int Y_BITS      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          tx_valid,
  output logic                                          tx_ready,
  input  logic [X_BITS-1:0]                             tx_dst_x,
  input  logic [Y_BITS-1:0]                             tx_dst_y,
  input  logic [1:0]                                    tx_ctrl,
  input  logic [PAYLOAD-1:0]                            tx_payload,
  output logic                                          net_req_o,
  input  logic                                          net_ack_i,
  output logic [pkt_w(PAYLOAD, X_BITS, Y_BITS)-1:0]     net_data_o,
  input  logic                                          net_req_i,
  output logic                                          net_ack_o,
  input  logic [pkt_w(PAYLOAD, X_BITS, Y_BITS)-1:0]     net_data_i,
  output logic                                          rx_valid,
  input  logic                                          rx_ready,
  output logic [X_BITS-1:0]                             rx_dst_x,
  output logic [Y_BITS-1:0]                             rx_dst_y,
  output logic [1:0]                                    rx_ctrl,
  output logic [PAYLOAD-1:0]                            rx_payload
);

  localparam int         PKT_W  = pkt_w(PAYLOAD, X_BITS, Y_BITS);
  localparam logic [1:0] SETTLE = 2'(SYNC_STAGES);

  logic ack_sync;
  logic req_sync;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d   (net_ack_i),
    .q   (ack_sync)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   (net_req_i),
    .q   (req_sync)
  );

  tx_state_t        tx_state_q, tx_state_d;
  logic             net_req_q, net_req_d;
  logic [PKT_W-1:0] net_data_q, net_data_d;
  logic [1:0]       settle_q, settle_d;

  rx_state_t        rx_state_q, rx_state_d;
  logic             net_ack_q, net_ack_d;
  logic [PKT_W-1:0] buf_q, buf_d;
  logic             full_q, full_d;

  // Reset clears the ack synchronizer, so a still-high router ack would read
  // as low for a while; hold TX off until the chain has refilled.
  assign tx_ready = (tx_state_q == TX_IDLE) && !ack_sync && (settle_q == 2'd0);

  always_comb begin
    tx_state_d = tx_state_q;
    net_req_d  = net_req_q;
    net_data_d = net_data_q;
    settle_d   = (settle_q != 2'd0) ? settle_q - 2'd1 : settle_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid && tx_ready) begin
          net_data_d = {tx_dst_x, tx_dst_y, tx_ctrl, tx_payload};
          net_req_d  = 1'b1;
          tx_state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        if (ack_sync) begin
          net_req_d  = 1'b0;
          tx_state_d = TX_REL;
        end
      end
      TX_REL: begin
        if (!ack_sync) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Capture is gated on full_q, not full_d: a drain and a refill never share an edge.
  always_comb begin
    rx_state_d = rx_state_q;
    net_ack_d  = net_ack_q;
    buf_d      = buf_q;
    full_d     = full_q;
    if (full_q && rx_ready) begin
      full_d = 1'b0;
    end
    case (rx_state_q)
      RX_IDLE: begin
        if (req_sync && !full_q) begin
          buf_d      = net_data_i;
          full_d     = 1'b1;
          net_ack_d  = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!req_sync) begin
          net_ack_d  = 1'b0;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      net_req_q  <= 1'b0;
      net_data_q <= '0;
      settle_q   <= SETTLE;
      rx_state_q <= RX_IDLE;
      net_ack_q  <= 1'b0;
      buf_q      <= '0;
      full_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      net_req_q  <= net_req_d;
      net_data_q <= net_data_d;
      settle_q   <= settle_d;
      rx_state_q <= rx_state_d;
      net_ack_q  <= net_ack_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
    end
  end

  assign net_req_o  = net_req_q;
  assign net_data_o = net_data_q;
  assign net_ack_o  = net_ack_q;
  assign rx_valid   = full_q;
  assign rx_dst_x   = buf_q[PKT_W-1 -: X_BITS];
  assign rx_dst_y   = buf_q[PAYLOAD+2 +: Y_BITS];
  assign rx_ctrl    = buf_q[PAYLOAD +: 2];
  assign rx_payload = buf_q[PAYLOAD-1:0];

endmodule

// File: tb/tb_noc_endpoint.sv
// Directed bench for noc_endpoint: TX/RX handshakes, backpressure, reset mid-handshake.
module tb_noc_endpoint;

  logic        clk;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:0]  tx_dst_x;
  logic [0:0]  tx_dst_y;
  logic [1:0]  tx_ctrl;
  logic [31:0] tx_payload;
  logic        net_req_o;
  logic        net_ack_i;
  logic [35:0] net_data_o;
  logic        net_req_i;
  logic        net_ack_o;
  logic [35:0] net_data_i;
  logic        rx_valid;
  logic        rx_ready;
  logic [0:0]  rx_dst_x;
  logic [0:0]  rx_dst_y;
  logic [1:0]  rx_ctrl;
  logic [31:0] rx_payload;

  int n_cmp = 0;
  int n_err = 0;

  noc_endpoint #(
    .PAYLOAD     (32),
    .X_BITS      (1),
    .Y_BITS      (1),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_dst_x   (tx_dst_x),
    .tx_dst_y   (tx_dst_y),
    .tx_ctrl    (tx_ctrl),
    .tx_payload (tx_payload),
    .net_req_o  (net_req_o),
    .net_ack_i  (net_ack_i),
    .net_data_o (net_data_o),
    .net_req_i  (net_req_i),
    .net_ack_o  (net_ack_o),
    .net_data_i (net_data_i),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_dst_x   (rx_dst_x),
    .rx_dst_y   (rx_dst_y),
    .rx_ctrl    (rx_ctrl),
    .rx_payload (rx_payload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic x, input logic y, input logic [1:0] c, input logic [31:0] p);
    tx_valid   = 1'b1;
    tx_dst_x   = x;
    tx_dst_y   = y;
    tx_ctrl    = c;
    tx_payload = p;
  endtask

  initial begin
    rst        = 1'b0;
    tx_valid   = 1'b0;
    tx_dst_x   = '0;
    tx_dst_y   = '0;
    tx_ctrl    = '0;
    tx_payload = '0;
    net_ack_i  = 1'b0;
    net_req_i  = 1'b0;
    net_data_i = '0;
    rx_ready   = 1'b0;

    // reset state
    step(2);
    chk("rst_req", 64'(net_req_o), 64'd0);
    chk("rst_ack", 64'(net_ack_o), 64'd0);
    chk("rst_data", 64'(net_data_o), 64'd0);
    chk("rst_rxvalid", 64'(rx_valid), 64'd0);
    chk("rst_rxpay", 64'(rx_payload), 64'd0);
    rst = 1'b1;
    step(2);
    chk("idle_ready", 64'(tx_ready), 64'd1);

    // TX: dst(1,0) ctrl 01 payload DEADBEEF, ack 3 cycles after req
    offer(1'b1, 1'b0, 2'b01, 32'hDEADBEEF);
    step(1);
    tx_valid = 1'b0;
    chk("tx1_req_rise", 64'(net_req_o), 64'd1);
    chk("tx1_data", 64'(net_data_o), 64'h9_DEADBEEF);
    chk("tx1_busy", 64'(tx_ready), 64'd0);
    step(3);
    chk("tx1_req_hold", 64'(net_req_o), 64'd1);
    net_ack_i = 1'b1;
    step(2);
    chk("tx1_req_pre_sync", 64'(net_req_o), 64'd1);
    step(1);
    chk("tx1_req_fall", 64'(net_req_o), 64'd0);
    chk("tx1_data_stable", 64'(net_data_o), 64'h9_DEADBEEF);
    net_ack_i = 1'b0;
    step(2);
    chk("tx1_rel_busy", 64'(tx_ready), 64'd0);
    step(1);
    chk("tx1_ready_back", 64'(tx_ready), 64'd1);
    chk("tx1_data_idle", 64'(net_data_o), 64'h9_DEADBEEF);

    // RX: 36'h5_12345678, rx_ready=1
    rx_ready   = 1'b1;
    net_data_i = 36'h5_12345678;
    net_req_i  = 1'b1;
    step(2);
    chk("rx1_not_yet", 64'(rx_valid), 64'd0);
    chk("rx1_ack_low", 64'(net_ack_o), 64'd0);
    step(1);
    chk("rx1_valid", 64'(rx_valid), 64'd1);
    chk("rx1_ack", 64'(net_ack_o), 64'd1);
    chk("rx1_pay", 64'(rx_payload), 64'h12345678);
    chk("rx1_x", 64'(rx_dst_x), 64'd0);
    chk("rx1_y", 64'(rx_dst_y), 64'd1);
    chk("rx1_ctrl", 64'(rx_ctrl), 64'd1);
    step(1);
    chk("rx1_drained", 64'(rx_valid), 64'd0);
    chk("rx1_ack_held", 64'(net_ack_o), 64'd1);
    net_req_i = 1'b0;
    step(2);
    chk("rx1_ack_still", 64'(net_ack_o), 64'd1);
    step(1);
    chk("rx1_ack_fall", 64'(net_ack_o), 64'd0);

    // RX backpressure: two packets with rx_ready=0
    rx_ready   = 1'b0;
    net_data_i = 36'h0_AAAA0001;
    net_req_i  = 1'b1;
    step(3);
    chk("bp_a_valid", 64'(rx_valid), 64'd1);
    chk("bp_a_ack", 64'(net_ack_o), 64'd1);
    net_req_i = 1'b0;
    step(3);
    chk("bp_a_ack_fall", 64'(net_ack_o), 64'd0);
    chk("bp_a_kept", 64'(rx_valid), 64'd1);
    net_data_i = 36'hF_BBBB0002;
    net_req_i  = 1'b1;
    step(5);
    chk("bp_b_withheld", 64'(net_ack_o), 64'd0);
    chk("bp_a_pay", 64'(rx_payload), 64'hAAAA0001);
    chk("bp_a_ctrl", 64'(rx_ctrl), 64'd0);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("bp_drain", 64'(rx_valid), 64'd0);
    chk("bp_no_same_cycle", 64'(net_ack_o), 64'd0);
    step(1);
    chk("bp_b_valid", 64'(rx_valid), 64'd1);
    chk("bp_b_ack", 64'(net_ack_o), 64'd1);
    chk("bp_b_pay", 64'(rx_payload), 64'hBBBB0002);
    chk("bp_b_x", 64'(rx_dst_x), 64'd1);
    chk("bp_b_y", 64'(rx_dst_y), 64'd1);
    chk("bp_b_ctrl", 64'(rx_ctrl), 64'd3);
    rx_ready  = 1'b1;
    net_req_i = 1'b0;
    step(1);
    chk("bp_b_drain", 64'(rx_valid), 64'd0);
    step(2);
    chk("bp_b_ack_fall", 64'(net_ack_o), 64'd0);

    // tx_valid presented while TX_REQ
    offer(1'b0, 1'b1, 2'b10, 32'h11111111);
    step(1);
    chk("tv_p1_data", 64'(net_data_o), 64'h6_11111111);
    offer(1'b1, 1'b1, 2'b11, 32'h22222222);
    chk("tv_busy", 64'(tx_ready), 64'd0);
    net_ack_i = 1'b1;
    step(3);
    chk("tv_req_fall", 64'(net_req_o), 64'd0);
    chk("tv_rel_busy", 64'(tx_ready), 64'd0);
    chk("tv_p1_held", 64'(net_data_o), 64'h6_11111111);
    net_ack_i = 1'b0;
    step(3);
    chk("tv_ready", 64'(tx_ready), 64'd1);
    step(1);
    tx_valid = 1'b0;
    chk("tv_p2_req", 64'(net_req_o), 64'd1);
    chk("tv_p2_data", 64'(net_data_o), 64'hF_22222222);
    net_ack_i = 1'b1;
    step(3);
    chk("tv_p2_req_fall", 64'(net_req_o), 64'd0);
    net_ack_i = 1'b0;
    step(3);
    chk("tv_p2_done", 64'(tx_ready), 64'd1);

    // reset during TX_REQ with ack still high
    offer(1'b0, 1'b0, 2'b00, 32'h33333333);
    step(1);
    chk("rs_req", 64'(net_req_o), 64'd1);
    offer(1'b1, 1'b0, 2'b01, 32'h44444444);
    net_ack_i = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("rs_req_drop", 64'(net_req_o), 64'd0);
    chk("rs_data_zero", 64'(net_data_o), 64'd0);
    chk("rs_not_ready", 64'(tx_ready), 64'd0);
    step(1);
    chk("rs_hold1", 64'(tx_ready), 64'd0);
    step(1);
    chk("rs_hold2", 64'(tx_ready), 64'd0);
    step(2);
    chk("rs_hold3", 64'(tx_ready), 64'd0);
    chk("rs_no_req", 64'(net_req_o), 64'd0);
    net_ack_i = 1'b0;
    step(1);
    chk("rs_hold4", 64'(tx_ready), 64'd0);
    step(1);
    chk("rs_ready", 64'(tx_ready), 64'd1);
    step(1);
    tx_valid = 1'b0;
    chk("rs_p4_req", 64'(net_req_o), 64'd1);
    chk("rs_p4_data", 64'(net_data_o), 64'h9_44444444);
    net_ack_i = 1'b1;
    step(3);
    chk("rs_p4_req_fall", 64'(net_req_o), 64'd0);
    net_ack_i = 1'b0;
    step(3);
    chk("rs_p4_done", 64'(tx_ready), 64'd1);

    // concurrent TX and RX
    rx_ready   = 1'b1;
    offer(1'b1, 1'b1, 2'b10, 32'hCAFEF00D);
    net_data_i = 36'hA_0BADF00D;
    net_req_i  = 1'b1;
    step(1);
    tx_valid = 1'b0;
    chk("cc_tx_req", 64'(net_req_o), 64'd1);
    chk("cc_tx_data", 64'(net_data_o), 64'hE_CAFEF00D);
    chk("cc_rx_early", 64'(rx_valid), 64'd0);
    net_ack_i = 1'b1;
    step(2);
    chk("cc_rx_valid", 64'(rx_valid), 64'd1);
    chk("cc_rx_pay", 64'(rx_payload), 64'h0BADF00D);
    chk("cc_rx_x", 64'(rx_dst_x), 64'd1);
    chk("cc_rx_y", 64'(rx_dst_y), 64'd0);
    chk("cc_rx_ctrl", 64'(rx_ctrl), 64'd2);
    chk("cc_tx_req_hold", 64'(net_req_o), 64'd1);
    chk("cc_tx_data_hold", 64'(net_data_o), 64'hE_CAFEF00D);
    step(1);
    chk("cc_tx_req_fall", 64'(net_req_o), 64'd0);
    chk("cc_rx_drain", 64'(rx_valid), 64'd0);
    chk("cc_rx_ack", 64'(net_ack_o), 64'd1);
    net_ack_i = 1'b0;
    net_req_i = 1'b0;
    step(3);
    chk("cc_rx_ack_fall", 64'(net_ack_o), 64'd0);
    chk("cc_tx_ready", 64'(tx_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
